axil_cmd_master: RTL and testbench
==================================

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 Parameter AW, default 32: AXI4-lite and command address width.
REQ-002 Parameter DW, default 32: data width, 32 or 64; strobe width is DW/8.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: transaction abort limit in aclk cycles, minimum 2.
REQ-004 aclk  in  1  sole clock; all logic on its rising edge.
REQ-005 aresetn  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when both valid and ready are high.
REQ-008 cmd_we  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  AW  byte address.
REQ-010 cmd_wdata  in  DW  write data; ignored for reads.
REQ-011 cmd_wstrb  in  DW/8  write byte strobes; ignored for reads.
REQ-012 rsp_valid  out  1  completion available.
REQ-013 rsp_ready  in  1  completion consumed when both valid and ready are high.
REQ-014 rsp_rdata  out  DW  read data; zero for writes.
REQ-015 rsp_resp  out  2  BRESP or RRESP value; 2'b10 on timeout.
REQ-016 rsp_timeout  out  1  completion was produced by timeout.
REQ-017 bus  axi4_lite_if master modport  AXI4-lite initiator; connects to a crossbar master port or directly to an AXI4-lite responder.

Function
REQ-018 One outstanding transaction at a time; no pipelining of commands.
REQ-019 FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
REQ-020 IDLE: cmd_ready=1; on accept, latch addr, wdata, wstrb and we, then go to WR_REQ if we=1, otherwise RD_REQ.
REQ-021 cmd_ready shall be 0 in every state other than IDLE.
REQ-022 WR_REQ: awvalid and wvalid rise together in the cycle after the command is accepted.
REQ-023 In WR_REQ, each of awvalid and wvalid drops independently in the cycle after its own handshake; when both channels are done, go to WR_RESP.
REQ-024 WR_RESP: bready=1; on bvalid, capture bresp into rsp_resp, set rsp_rdata=0 and go to RSP.
REQ-025 RD_REQ: arvalid=1 until the arready handshake, then go to RD_DATA.
REQ-026 RD_DATA: rready=1; on rvalid, capture rdata and rresp, then go to RSP.
REQ-027 RSP: rsp_valid=1 with all rsp_* fields stable; on rsp_ready, go to IDLE.
REQ-028 awvalid, wvalid and arvalid, once high, shall stay high with stable payload until their handshake.
REQ-029 awprot and arprot shall be 3'b000.
REQ-030 A handshake already pending when a channel's valid rises (ready held high) shall complete in that same cycle.
REQ-031 Minimum latency is 4 cycles from command accept to rsp_valid, with a zero-wait responder.
REQ-032 rsp_ready asserted while the block is outside RSP shall be ignored.

Reset
REQ-033 While aresetn=0: state is IDLE; cmd_ready=1; rsp_valid=0; rsp_rdata=0; rsp_resp=0; rsp_timeout=0; all AXI valid and ready outputs are 0; the timeout counter is 0.
REQ-034 Reset asserted mid-transaction abandons that transaction with no completion issued; the responder shall be reset in the same domain.

Configuration
REQ-035 Macro AXIL_CMD_MASTER_TIMEOUT_EN defined: a counter clears on command accept and counts every cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
REQ-036 When the counter reaches TIMEOUT_CYCLES, all AXI valid and ready outputs drop, and the block enters RSP with rsp_resp=2'b10, rsp_timeout=1 and rsp_rdata=0.
REQ-037 A handshake occurring in the same cycle as expiry wins, and no timeout is reported.
REQ-038 Dropping a valid before its handshake on timeout is a deliberate recovery deviation from AXI4-lite; a late response from the abandoned transaction is a system error.
REQ-039 Macro AXIL_CMD_MASTER_TIMEOUT_EN undefined: no counter is built, rsp_timeout is tied to 0, and the block waits indefinitely.

Verification
REQ-040 Write 0x0000_0010 / 0xDEAD_BEEF / strobe 4'hF to a zero-wait memory -> AW and W in the same cycle; rsp_valid 4 cycles after accept; rsp_resp=00; a readback returns 0xDEADBEEF.
REQ-041 awready delayed 3 cycles while wready is immediate -> wvalid drops after 1 cycle; awvalid held with stable awaddr; B accepted once.
REQ-042 Read while the responder returns rresp=2'b10 and rdata=0x1234_5678 -> rsp_resp=10; rsp_rdata=0x12345678; rsp_timeout=0.
REQ-043 rsp_ready held low for 5 cycles -> rsp fields stable; cmd_ready=0 throughout; a new command is accepted in the cycle after rsp_ready.
REQ-044 With TIMEOUT_EN defined and TIMEOUT_CYCLES=8, read to a non-responding slave -> after 8 cycles arvalid=0, rsp_resp=10, rsp_timeout=1; without the macro, still waiting after 100 cycles.
REQ-045 aresetn pulsed low during WR_RESP -> all outputs take their REQ-033 values immediately; no rsp_valid; the next command completes normally.

Source files
------------

// File: rtl/axil_cmd_master_if.sv
// AXI4-lite channel bundle between one initiator and one responder.
interface axi4_lite_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          awvalid;
  logic          awready;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          bvalid;
  logic          bready;
  logic [1:0]    bresp;
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;

  modport master (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr, arprot,
    output rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr, arprot,
    input  rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding command-to-AXI4-lite initiator.
// Optional abort timer: define AXIL_CMD_MASTER_TIMEOUT_EN.
module axil_cmd_master #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [DW/8-1:0] cmd_wstrb,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic [1:0]      rsp_resp,
  output logic            rsp_timeout,
  axi4_lite_if.master     bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;
  localparam logic [2:0] RSP     = 3'd5;

  logic [2:0]      state;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            aw_q;
  logic            w_q;
  logic            ar_q;
  logic            accept;
  logic            expire;

  assign accept    = cmd_valid && (state == IDLE);
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RSP);

  assign bus.awvalid = aw_q;
  assign bus.awaddr  = addr;
  assign bus.awprot  = 3'b000;
  assign bus.wvalid  = w_q;
  assign bus.wdata   = wdata;
  assign bus.wstrb   = wstrb;
  assign bus.bready  = (state == WR_RESP);
  assign bus.arvalid = ar_q;
  assign bus.araddr  = addr;
  assign bus.arprot  = 3'b000;
  assign bus.rready  = (state == RD_DATA);

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;
  logic          busy;
  logic          progress;
  logic          to_q;

  assign busy = (state == WR_REQ) || (state == WR_RESP) ||
                (state == RD_REQ) || (state == RD_DATA);

  // Any handshake this cycle beats an expiry landing on the same edge.
  always_comb begin
    progress = 1'b0;
    case (state)
      WR_REQ:  progress = (aw_q && bus.awready) ||
                          (w_q && bus.wready) ||
                          (!aw_q && !w_q);
      WR_RESP: progress = bus.bvalid;
      RD_REQ:  progress = bus.arready;
      RD_DATA: progress = bus.rvalid;
      default: progress = 1'b0;
    endcase
  end

  assign expire = busy && !progress && (cnt >= LAST);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (busy && cnt != FULL) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      to_q <= 1'b0;
    end else if (accept) begin
      to_q <= 1'b0;
    end else if (expire) begin
      to_q <= 1'b1;
    end
  end

  assign rsp_timeout = to_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expire      = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      addr      <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      aw_q      <= 1'b0;
      w_q       <= 1'b0;
      ar_q      <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr  <= cmd_addr;
            wdata <= cmd_wdata;
            wstrb <= cmd_wstrb;
            if (cmd_we) begin
              aw_q  <= 1'b1;
              w_q   <= 1'b1;
              state <= WR_REQ;
            end else begin
              ar_q  <= 1'b1;
              state <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (expire) begin
            aw_q      <= 1'b0;
            w_q       <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b10;
            state     <= RSP;
          end else begin
            if (aw_q && bus.awready) aw_q <= 1'b0;
            if (w_q && bus.wready) w_q <= 1'b0;
            if (!aw_q && !w_q) state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bus.bvalid) begin
            rsp_rdata <= '0;
            rsp_resp  <= bus.bresp;
            state     <= RSP;
          end else if (expire) begin
            rsp_rdata <= '0;
            rsp_resp  <= 2'b10;
            state     <= RSP;
          end
        end
        RD_REQ: begin
          if (bus.arready) begin
            ar_q  <= 1'b0;
            state <= RD_DATA;
          end else if (expire) begin
            ar_q      <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b10;
            state     <= RSP;
          end
        end
        RD_DATA: begin
          if (bus.rvalid) begin
            rsp_rdata <= bus.rdata;
            rsp_resp  <= bus.rresp;
            state     <= RSP;
          end else if (expire) begin
            rsp_rdata <= '0;
            rsp_resp  <= 2'b10;
            state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: memory responder, scoreboard of completions.
module tb_axil_cmd_master;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } exp_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  axi4_lite_if #(.AW(32), .DW(32)) bus ();

  axil_cmd_master #(
    .AW(32),
    .DW(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we(cmd_we),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .bus(bus)
  );

  always #5 aclk = ~aclk;

  // Responder knobs
  int          aw_delay = 0;
  int          w_delay  = 0;
  int          ar_delay = 0;
  logic        silent   = 1'b0;
  logic        b_silent = 1'b0;
  logic        r_force  = 1'b0;
  logic [1:0]  b_resp_cfg = 2'b00;
  logic [1:0]  r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = 32'h0;

  logic [31:0] mem [0:255];
  int          aw_wait, w_wait, ar_wait;
  logic        got_aw, got_w;
  logic [31:0] aw_a, w_d;
  logic [3:0]  w_s;
  logic        aw_hs, w_hs, have_aw, have_w;
  logic [31:0] cur_a, cur_d;
  logic [3:0]  cur_s;

  assign bus.awready = !silent && (aw_delay == 0 ||
                       (bus.awvalid && aw_wait >= aw_delay));
  assign bus.wready  = !silent && (w_delay == 0 ||
                       (bus.wvalid && w_wait >= w_delay));
  assign bus.arready = !silent && (ar_delay == 0 ||
                       (bus.arvalid && ar_wait >= ar_delay));

  assign aw_hs   = bus.awvalid && bus.awready;
  assign w_hs    = bus.wvalid && bus.wready;
  assign have_aw = got_aw || aw_hs;
  assign have_w  = got_w || w_hs;
  assign cur_a   = got_aw ? aw_a : bus.awaddr;
  assign cur_d   = got_w ? w_d : bus.wdata;
  assign cur_s   = got_w ? w_s : bus.wstrb;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bus.bvalid <= 1'b0;
      bus.bresp  <= 2'b00;
      bus.rvalid <= 1'b0;
      bus.rdata  <= 32'h0;
      bus.rresp  <= 2'b00;
      got_aw <= 1'b0;
      got_w  <= 1'b0;
      aw_a <= 32'h0;
      w_d  <= 32'h0;
      w_s  <= 4'h0;
      aw_wait <= 0;
      w_wait  <= 0;
      ar_wait <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else begin
      aw_wait <= (bus.awvalid && !bus.awready) ? aw_wait + 1 : 0;
      w_wait  <= (bus.wvalid && !bus.wready) ? w_wait + 1 : 0;
      ar_wait <= (bus.arvalid && !bus.arready) ? ar_wait + 1 : 0;
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if (have_aw && have_w && !bus.bvalid && !b_silent) begin
        for (int i = 0; i < 4; i++)
          if (cur_s[i]) mem[cur_a[9:2]][8*i +: 8] <= cur_d[8*i +: 8];
        bus.bvalid <= 1'b1;
        bus.bresp  <= b_resp_cfg;
        got_aw <= 1'b0;
        got_w  <= 1'b0;
      end else begin
        got_aw <= have_aw;
        got_w  <= have_w;
        if (aw_hs) aw_a <= bus.awaddr;
        if (w_hs) begin
          w_d <= bus.wdata;
          w_s <= bus.wstrb;
        end
      end
      if (bus.arvalid && bus.arready) begin
        bus.rvalid <= 1'b1;
        bus.rdata  <= r_force ? r_data_cfg : mem[bus.araddr[9:2]];
        bus.rresp  <= r_resp_cfg;
      end else if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0;
      end
    end
  end

  // Bus monitor: cumulative counters, tasks take differences
  int          cyc = 0;
  int          aw_hs_cyc = -1;
  int          w_hs_cyc  = -2;
  int          wv_cnt = 0, awv_cnt = 0, arv_cnt = 0, b_cnt = 0;
  int          aw_chg = 0;
  logic        prev_awv = 1'b0;
  logic [31:0] prev_awaddr = 32'h0;

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (aw_hs) aw_hs_cyc <= cyc;
    if (w_hs) w_hs_cyc <= cyc;
    if (bus.wvalid) wv_cnt <= wv_cnt + 1;
    if (bus.awvalid) awv_cnt <= awv_cnt + 1;
    if (bus.arvalid) arv_cnt <= arv_cnt + 1;
    if (bus.bvalid && bus.bready) b_cnt <= b_cnt + 1;
    if (bus.awvalid && prev_awv && bus.awaddr != prev_awaddr)
      aw_chg <= aw_chg + 1;
    prev_awv    <= bus.awvalid;
    prev_awaddr <= bus.awaddr;
  end

  task automatic send_cmd(input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge aclk);
    cmd_we = we;
    cmd_addr = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, need 1",
               cmd_ready, n);
    end
    @(posedge aclk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input int budget, output int lat);
    exp_t e;
    lat = 0;
    do begin
      @(negedge aclk);
      lat++;
    end while (!rsp_valid && lat < budget);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, need 1",
               rsp_valid, lat);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL rsp_unexpected: rdata=%h with empty scoreboard",
               rsp_rdata);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (rsp_rdata !== e.rdata) begin
        errors++;
        $display("FAIL rsp_rdata: got %h need %h", rsp_rdata, e.rdata);
      end
      checks++;
      if (rsp_resp !== e.resp) begin
        errors++;
        $display("FAIL rsp_resp: got %b need %b", rsp_resp, e.resp);
      end
      checks++;
      if (rsp_timeout !== e.to) begin
        errors++;
        $display("FAIL rsp_timeout: got %b need %b", rsp_timeout, e.to);
      end
    end
    rsp_ready = 1'b1;
    @(posedge aclk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    logic [10:0] got;
    got = {cmd_ready, rsp_valid, rsp_timeout, rsp_resp,
           bus.awvalid, bus.wvalid, bus.arvalid, bus.bready,
           bus.rready, |{bus.awprot, bus.arprot}};
    checks++;
    if (got !== 11'b100_00_00000_0) begin
      errors++;
      $display("FAIL %s_ctrl: got %b need %b", tag, got, 11'b10000000000);
    end
    checks++;
    if (rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL %s_rdata: got %h need 0", tag, rsp_rdata);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check_idle_outputs("reset");
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_write_read();
    int lat;
    exp_q.push_back('{32'h0, 2'b00, 1'b0});
    send_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    get_rsp(200, lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL write_latency: got %0d need 4", lat);
    end
    checks++;
    if (aw_hs_cyc != w_hs_cyc) begin
      errors++;
      $display("FAIL aw_w_same_cycle: aw at %0d w at %0d",
               aw_hs_cyc, w_hs_cyc);
    end
    exp_q.push_back('{32'hDEAD_BEEF, 2'b00, 1'b0});
    send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
    get_rsp(200, lat);
  endtask

  task automatic test_aw_delay();
    int lat, wv0, awv0, b0, chg0;
    aw_delay = 3;
    wv0 = wv_cnt; awv0 = awv_cnt; b0 = b_cnt; chg0 = aw_chg;
    exp_q.push_back('{32'h0, 2'b00, 1'b0});
    send_cmd(1'b1, 32'h20, 32'hCAFE_F00D, 4'b0101);
    get_rsp(200, lat);
    aw_delay = 0;
    checks++;
    if (wv_cnt - wv0 != 1) begin
      errors++;
      $display("FAIL wvalid_cycles: got %0d need 1", wv_cnt - wv0);
    end
    checks++;
    if (awv_cnt - awv0 != 4) begin
      errors++;
      $display("FAIL awvalid_cycles: got %0d need 4", awv_cnt - awv0);
    end
    checks++;
    if (aw_chg - chg0 != 0) begin
      errors++;
      $display("FAIL awaddr_stable: %0d changes need 0", aw_chg - chg0);
    end
    checks++;
    if (b_cnt - b0 != 1) begin
      errors++;
      $display("FAIL b_count: got %0d need 1", b_cnt - b0);
    end
    checks++;
    if (lat != 7) begin
      errors++;
      $display("FAIL aw_delay_latency: got %0d need 7", lat);
    end
    exp_q.push_back('{32'h00FE_000D, 2'b00, 1'b0});
    send_cmd(1'b0, 32'h20, 32'h0, 4'h0);
    get_rsp(200, lat);
  endtask

  task automatic test_resp_codes();
    int lat;
    r_force = 1'b1;
    r_resp_cfg = 2'b10;
    r_data_cfg = 32'h1234_5678;
    exp_q.push_back('{32'h1234_5678, 2'b10, 1'b0});
    send_cmd(1'b0, 32'h30, 32'h0, 4'h0);
    get_rsp(200, lat);
    r_force = 1'b0;
    r_resp_cfg = 2'b00;
    b_resp_cfg = 2'b11;
    exp_q.push_back('{32'h0, 2'b11, 1'b0});
    send_cmd(1'b1, 32'h34, 32'h7777_7777, 4'hF);
    get_rsp(200, lat);
    b_resp_cfg = 2'b00;
  endtask

  task automatic test_rsp_stall();
    int lat, n, bad;
    exp_t e;
    exp_q.push_back('{32'h0, 2'b00, 1'b0});
    send_cmd(1'b1, 32'h60, 32'h1122_3344, 4'hF);
    get_rsp(200, lat);
    exp_q.push_back('{32'h1122_3344, 2'b00, 1'b0});
    send_cmd(1'b0, 32'h60, 32'h0, 4'h0);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge aclk);
      n++;
    end
    e = exp_q.pop_front();
    cmd_we = 1'b1;
    cmd_addr = 32'h70;
    cmd_wdata = 32'hA5A5_A5A5;
    cmd_wstrb = 4'hF;
    cmd_valid = 1'b1;
    exp_q.push_back('{32'h0, 2'b00, 1'b0});
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata ||
          rsp_resp !== e.resp || cmd_ready !== 1'b0) bad++;
      @(negedge aclk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_stable: %0d bad cycles need 0 (rdata %h)",
               bad, rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(posedge aclk);
    #1 rsp_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: cmd_ready=%b rsp_valid=%b need 1 0",
               cmd_ready, rsp_valid);
    end
    @(posedge aclk);
    #1 cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_next_accept: cmd_ready=%b need 0", cmd_ready);
    end
    get_rsp(200, lat);
    exp_q.push_back('{32'hA5A5_A5A5, 2'b00, 1'b0});
    send_cmd(1'b0, 32'h70, 32'h0, 4'h0);
    get_rsp(200, lat);
  endtask

  task automatic test_timeout();
    int lat, ar0, n;
    ar0 = arv_cnt;
    silent = 1'b1;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    exp_q.push_back('{32'h0, 2'b10, 1'b1});
    send_cmd(1'b0, 32'h40, 32'h0, 4'h0);
    get_rsp(200, lat);
    checks++;
    if (lat != 9 || arv_cnt - ar0 != 8) begin
      errors++;
      $display("FAIL timeout_timing: lat %0d ar %0d need 9 8",
               lat, arv_cnt - ar0);
    end
    silent = 1'b0;
`else
    send_cmd(1'b0, 32'h40, 32'h0, 4'h0);
    n = 0;
    repeat (100) begin
      @(negedge aclk);
      if (rsp_valid !== 1'b0 || bus.arvalid !== 1'b1) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL no_timeout_wait: %0d bad cycles need 0", n);
    end
    exp_q.push_back('{32'h0, 2'b00, 1'b0});
    silent = 1'b0;
    get_rsp(200, lat);
    checks++;
    if (arv_cnt - ar0 < 100) begin
      errors++;
      $display("FAIL no_timeout_ar: %0d cycles need >=100", arv_cnt - ar0);
    end
`endif
    ar_delay = 7;
    exp_q.push_back('{32'hDEAD_BEEF, 2'b00, 1'b0});
    send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
    get_rsp(200, lat);
    ar_delay = 0;
    checks++;
    if (lat != 10) begin
      errors++;
      $display("FAIL expiry_race_latency: got %0d need 10", lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat, n;
    b_silent = 1'b1;
    send_cmd(1'b1, 32'h80, 32'h0000_0055, 4'hF);
    n = 0;
    while (!bus.bready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (bus.bready !== 1'b1) begin
      errors++;
      $display("FAIL reach_wr_resp: bready=%b need 1", bus.bready);
    end
    aresetn = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge aclk);
    aresetn = 1'b1;
    b_silent = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge aclk);
      if (rsp_valid !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL abandoned_rsp: rsp_valid seen %0d cycles need 0", n);
    end
    exp_q.push_back('{32'h0, 2'b00, 1'b0});
    send_cmd(1'b1, 32'h80, 32'h1234_4321, 4'hF);
    get_rsp(200, lat);
    exp_q.push_back('{32'h1234_4321, 2'b00, 1'b0});
    send_cmd(1'b0, 32'h80, 32'h0, 4'h0);
    get_rsp(200, lat);
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_we = 1'b0;
    cmd_addr = 32'h0;
    cmd_wdata = 32'h0;
    cmd_wstrb = 4'h0;
    rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_aw_delay();
    test_resp_codes();
    test_rsp_stall();
    test_timeout();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left need 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
